// File: rtl/queue_ctrl_pkg.sv
// Shared definitions for the inter-pass boundary queue sequencer.
// Queue geometry defaults and FSM state encodings.
package queue_ctrl_pkg;

    localparam int QUEUE_SIZE     = 256;
    localparam int QUEUE_SIZE_LOG = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/queue_ctrl.sv
// Sequencer for the Smith-Waterman inter-pass boundary queue: issues init/store/take
// strobes, tracks occupancy, counts passes and per-pass elements.
module queue_ctrl #(
    parameter int QUEUE_SIZE     = queue_ctrl_pkg::QUEUE_SIZE,
    parameter int QUEUE_SIZE_LOG = queue_ctrl_pkg::QUEUE_SIZE_LOG,
    parameter int LEN_W          = 10,
    parameter int PASS_W         = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [LEN_W-1:0]        i_t_len,
    input  logic [PASS_W-1:0]       i_num_pass,
    input  logic                    i_st_valid,
    output logic                    o_st_ready,
    input  logic                    i_tk_req,
    output logic                    o_tk_grant,
    output logic                    o_q_init,
    output logic                    o_q_store,
    output logic                    o_q_take,
    output logic [QUEUE_SIZE_LOG:0] o_count,
    output logic [PASS_W-1:0]       o_pass,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);
    import queue_ctrl_pkg::*;

    localparam logic [QUEUE_SIZE_LOG:0] QS_CNT = (QUEUE_SIZE_LOG+1)'(QUEUE_SIZE);
    localparam logic [LEN_W:0]          QS_LEN = (LEN_W+1)'(QUEUE_SIZE);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LEN_W-1:0]        r_t_len;
    logic [LEN_W-1:0]        r_st_cnt;
    logic [LEN_W-1:0]        r_tk_cnt;
    logic [LEN_W-1:0]        w_st_goal;
    logic [LEN_W-1:0]        w_tk_goal;
    logic [LEN_W-1:0]        w_st_nxt;
    logic [LEN_W-1:0]        w_tk_nxt;
    logic [PASS_W-1:0]       r_num_pass;
    logic [PASS_W-1:0]       r_pass;
    logic [QUEUE_SIZE_LOG:0] r_count;
    logic                    r_q_init;
    logic                    r_err;
    logic                    w_cfg_bad;
    logic                    w_accept;
    logic                    w_abort;
    logic                    w_last;
    logic                    w_st_ready;
    logic                    w_tk_grant;
    logic                    w_store;
    logic                    w_take;
    logic                    w_pass_end;

    // A multi-pass run needs a whole pass to fit in the queue
    assign w_cfg_bad = (i_num_pass > PASS_W'(1)) && ({1'b0, i_t_len} > QS_LEN);
    assign w_accept  = (r_state == IDLE) && i_start && !w_cfg_bad;
    assign w_abort   = (r_state != IDLE) && i_abort;
    // Covers N==0 and N==1: pass 0 is already the last pass
    assign w_last    = ({1'b0, r_pass} + (PASS_W+1)'(1)) >= {1'b0, r_num_pass};

    always_comb begin
        w_st_goal  = '0;
        w_tk_goal  = '0;
        w_st_ready = 1'b0;
        w_tk_grant = 1'b0;
        if (!w_last)
            w_st_goal = r_t_len;
        if (r_pass != '0)
            w_tk_goal = r_t_len;
        if (r_state == RUN) begin
            w_st_ready = (r_st_cnt < w_st_goal) && (r_count < QS_CNT);
            w_tk_grant = i_tk_req && (r_tk_cnt < w_tk_goal) && (r_count != '0);
        end
    end

    assign w_store    = i_st_valid && w_st_ready;
    assign w_take     = w_tk_grant;
    assign w_st_nxt   = r_st_cnt + LEN_W'(w_store);
    assign w_tk_nxt   = r_tk_cnt + LEN_W'(w_take);
    assign w_pass_end = (r_state == RUN) && (w_st_nxt == w_st_goal) && (w_tk_nxt == w_tk_goal);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = INIT;
            INIT: w_state_nxt = RUN;
            RUN:  if (w_pass_end && w_last) w_state_nxt = FIN;
            FIN:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_init   <= 1'b0;
            r_err      <= 1'b0;
            r_t_len    <= '0;
            r_num_pass <= '0;
            r_count    <= '0;
            r_pass     <= '0;
            r_st_cnt   <= '0;
            r_tk_cnt   <= '0;
        end else begin
            r_q_init <= w_accept || w_abort;
            r_err    <= (r_state == IDLE) && i_start && w_cfg_bad;
            if (w_accept) begin
                r_t_len    <= i_t_len;
                r_num_pass <= i_num_pass;
            end
            // Clearing on the accepting edge makes pass 0 visible during INIT
            if (w_accept || w_abort) begin
                r_count  <= '0;
                r_pass   <= '0;
                r_st_cnt <= '0;
                r_tk_cnt <= '0;
            end else if (r_state == RUN) begin
                case ({w_store, w_take})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                if (w_pass_end) begin
                    r_st_cnt <= '0;
                    r_tk_cnt <= '0;
                    if (!w_last)
                        r_pass <= r_pass + 1'b1;
                end else begin
                    r_st_cnt <= w_st_nxt;
                    r_tk_cnt <= w_tk_nxt;
                end
            end
        end
    end

    assign o_st_ready = w_st_ready;
    assign o_tk_grant = w_tk_grant;
    assign o_q_store  = w_store;
    assign o_q_take   = w_take;
    assign o_q_init   = r_q_init;
    assign o_count    = r_count;
    assign o_pass     = r_pass;
    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == FIN);
    assign o_err      = r_err;

endmodule

// File: tb/tb_queue_ctrl.sv
// Directed table-driven bench for queue_ctrl plus hand-written multi-cycle sequences.
module tb_queue_ctrl;

    localparam int LEN_W  = 10;
    localparam int PASS_W = 6;
    localparam int QS     = 256;
    localparam int QSL    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic              i_abort = 1'b0;
    logic [LEN_W-1:0]  i_t_len = '0;
    logic [PASS_W-1:0] i_num_pass = '0;
    logic              i_st_valid = 1'b0;
    logic              i_tk_req = 1'b0;
    logic              o_st_ready, o_tk_grant, o_q_init, o_q_store, o_q_take;
    logic [QSL:0]      o_count;
    logic [PASS_W-1:0] o_pass;
    logic              o_busy, o_done, o_err;

    queue_ctrl #(
        .QUEUE_SIZE(QS),
        .QUEUE_SIZE_LOG(QSL),
        .LEN_W(LEN_W),
        .PASS_W(PASS_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_t_len(i_t_len), .i_num_pass(i_num_pass),
        .i_st_valid(i_st_valid), .o_st_ready(o_st_ready),
        .i_tk_req(i_tk_req), .o_tk_grant(o_tk_grant),
        .o_q_init(o_q_init), .o_q_store(o_q_store), .o_q_take(o_q_take),
        .o_count(o_count), .o_pass(o_pass), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit start, abort; int t, n; bit sv, tr;
        bit e_init, e_busy, e_err, e_done, e_rdy, e_gnt; int e_cnt, e_pass;
    } vec_t;

    vec_t vt[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic row(input bit start, input bit abort, input int t, input int n,
                       input bit sv, input bit tr, input bit e_init, input bit e_busy,
                       input bit e_err, input bit e_done, input bit e_rdy, input bit e_gnt,
                       input int e_cnt, input int e_pass);
        vt.push_back('{start, abort, t, n, sv, tr, e_init, e_busy, e_err, e_done,
                       e_rdy, e_gnt, e_cnt, e_pass});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit start, input int t, input int n, input bit sv, input bit tr);
        i_start    = start;
        i_t_len    = LEN_W'(t);
        i_num_pass = PASS_W'(n);
        i_st_valid = sv;
        i_tk_req   = tr;
    endtask

    // Runs until o_done or the budget expires, tallying strobes seen in RUN
    task automatic run_to_done(input int budget, output int st, output int tk,
                               output int dn, output int mx);
        st = 0; tk = 0; dn = 0; mx = 0;
        for (int c = 0; c < budget && dn == 0; c++) begin
            @(negedge clk);
            if (o_q_store) st++;
            if (o_q_take) tk++;
            if (o_done) dn++;
            if (int'(o_count) > mx) mx = int'(o_count);
            if (o_q_take && o_count == 0) chk("take_at_empty", 1, 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int st, tk, dn, mx;

        // Config error: T>QUEUE_SIZE with N>1
        row(1,0,300,2,0,0, 0,0,0,0,0,0,0,0);
        row(0,0,0,0,0,0,   0,0,1,0,0,0,0,0);
        row(0,0,0,0,0,0,   0,0,0,0,0,0,0,0);
        // Basic flow T=4 N=3, both sides always active
        row(1,0,4,3,1,1,   0,0,0,0,0,0,0,0);
        row(0,0,0,0,1,1,   1,1,0,0,0,0,0,0);
        for (int c = 0; c < 4; c++) row(0,0,0,0,1,1, 0,1,0,0,1,0,c,0);
        for (int c = 0; c < 4; c++) row(c == 1,0,0,0,1,1, 0,1,0,0,1,1,4,1);
        for (int c = 0; c < 4; c++) row(0,0,0,0,1,1, 0,1,0,0,0,1,4-c,2);
        row(0,0,0,0,1,1,   0,1,0,1,0,0,0,2);
        row(0,0,0,0,1,1,   0,0,0,0,0,0,0,2);
        // Degenerate N=1 T=8
        row(1,0,8,1,1,1,   0,0,0,0,0,0,0,2);
        row(0,0,0,0,1,1,   1,1,0,0,0,0,0,0);
        row(0,0,0,0,1,1,   0,1,0,0,0,0,0,0);
        row(0,0,0,0,1,1,   0,1,0,1,0,0,0,0);
        row(0,0,0,0,0,0,   0,0,0,0,0,0,0,0);
        // Abort after 2 stores in pass 0, then abort while idle
        row(1,0,4,3,1,0,   0,0,0,0,0,0,0,0);
        row(0,0,0,0,1,0,   1,1,0,0,0,0,0,0);
        row(0,0,0,0,1,0,   0,1,0,0,1,0,0,0);
        row(0,0,0,0,1,0,   0,1,0,0,1,0,1,0);
        row(0,1,0,0,0,0,   0,1,0,0,1,0,2,0);
        row(0,0,0,0,0,0,   1,0,0,0,0,0,0,0);
        row(0,1,0,0,0,0,   0,0,0,0,0,0,0,0);
        row(0,0,0,0,0,0,   0,0,0,0,0,0,0,0);

        #2;
        chk("rst_busy", o_busy, 0);
        chk("rst_init", o_q_init, 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_pass", int'(o_pass), 0);
        chk("rst_done_err", {o_done, o_err}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].start, vt[i].t, vt[i].n, vt[i].sv, vt[i].tr);
            i_abort = vt[i].abort;
            @(negedge clk);
            chk($sformatf("v%0d_init", i), o_q_init, vt[i].e_init);
            chk($sformatf("v%0d_busy", i), o_busy, vt[i].e_busy);
            chk($sformatf("v%0d_err", i), o_err, vt[i].e_err);
            chk($sformatf("v%0d_done", i), o_done, vt[i].e_done);
            chk($sformatf("v%0d_rdy", i), o_st_ready, vt[i].e_rdy);
            chk($sformatf("v%0d_gnt", i), o_tk_grant, vt[i].e_gnt);
            chk($sformatf("v%0d_store", i), o_q_store, vt[i].e_rdy & vt[i].sv);
            chk($sformatf("v%0d_take", i), o_q_take, vt[i].e_gnt);
            chk($sformatf("v%0d_count", i), int'(o_count), vt[i].e_cnt);
            chk($sformatf("v%0d_pass", i), int'(o_pass), vt[i].e_pass);
            step();
        end
        i_abort = 1'b0;

        // Backpressure: T=256 N=2, consumer idle through pass 0
        drive(1, 256, 2, 1, 0);
        step();
        drive(0, 0, 0, 1, 0);
        step();
        st = 0;
        for (int c = 0; c < 600 && o_pass != 1; c++) begin
            @(negedge clk);
            if (o_q_store) st++;
            step();
        end
        @(negedge clk);
        chk("bp_stores", st, 256);
        chk("bp_count_full", int'(o_count), 256);
        chk("bp_ready_full", o_st_ready, 0);
        chk("bp_pass", int'(o_pass), 1);
        step();
        i_tk_req = 1'b1;
        run_to_done(700, st, tk, dn, mx);
        chk("bp_takes", tk, 256);
        chk("bp_p1_stores", st, 0);
        chk("bp_max", mx, 256);
        chk("bp_done", dn, 1);
        step();
        chk("bp_end_count", int'(o_count), 0);

        // Empty guard: T=2 N=3, take requests held while the queue is empty
        drive(1, 2, 3, 0, 1);
        step();
        drive(0, 0, 0, 0, 1);
        step();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("ug_p0_gnt", o_tk_grant, 0);
            step();
        end
        i_st_valid = 1'b1;
        step();
        step();
        i_st_valid = 1'b0;
        tk = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (o_tk_grant) tk++;
            step();
        end
        chk("ug_p1_takes", tk, 2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("ug_empty_count", int'(o_count), 0);
            chk("ug_empty_gnt", o_tk_grant, 0);
            step();
        end
        i_st_valid = 1'b1;
        run_to_done(40, st, tk, dn, mx);
        chk("ug_rest_stores", st, 2);
        chk("ug_rest_takes", tk, 2);
        chk("ug_done", dn, 1);
        step();

        // Async reset mid-RUN
        drive(1, 4, 3, 1, 1);
        step();
        drive(0, 0, 0, 1, 1);
        step();
        step();
        step();
        chk("ar_busy_before", o_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", o_busy, 0);
        chk("ar_count", int'(o_count), 0);
        chk("ar_strobes", {o_q_init, o_q_store, o_q_take, o_st_ready, o_tk_grant}, 0);
        chk("ar_pass_done", {o_pass, o_done, o_err}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ar_after_init", o_q_init, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
